ein_rx: RTL and testbench



---
 rtl/ein_pkg.sv | 16 +
 rtl/ein_filter.sv | 47 ++++
 rtl/ein_rx.sv | 144 ++++++++++++++
 tb/tb_ein_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ein_pkg.sv
// Shared constants and state type for the EMO/EDI/ECI receive path.
// Timing defaults are tied to the transmit-side link step period.
package ein_pkg;

    localparam int unsigned EIN_BITS_PER_CHAR  = 8;
    localparam int unsigned EIN_STEP_CYCLES    = 4000;
    localparam int unsigned EIN_FILTER_CYCLES  = 16;
    localparam int unsigned EIN_TIMEOUT_CYCLES = 10 * EIN_STEP_CYCLES;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN
    } ein_state_e;

endpackage

// File: rtl/ein_filter.sv
// Two-flop synchronizer plus debounce for one asynchronous pad wire.
// dout_edge pulses in the same cycle that dout takes its new value.
module ein_filter
    import ein_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = EIN_FILTER_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout,
    output logic dout_edge
);

    localparam int unsigned CW = $clog2(FILTER_CYCLES) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            dout      <= 1'b0;
            dout_edge <= 1'b0;
        end else begin
            sync1     <= din;
            sync2     <= sync1;
            dout_edge <= 1'b0;
            // Any sample matching the current output restarts the run.
            if (sync2 != dout) begin
                if (cnt == CW'(FILTER_CYCLES - 1)) begin
                    dout      <= sync2;
                    dout_edge <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ein_rx.sv
// Receive decoder for the EMO/EDI/ECI link: frames on EMO, samples EDI on
// every ECI toggle and presents MSB-first bytes on the out_frame handshake.
module ein_rx
    import ein_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = EIN_FILTER_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = EIN_TIMEOUT_CYCLES,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       EMO_PAD,
    input  logic       EDI_PAD,
    input  logic       ECI_PAD,
    output logic [7:0] out_frame_data,
    output logic       out_frame_data_latch,
    output logic       out_frame_valid,
    output logic       err_partial,
    output logic       err_timeout
);

    logic emo_f, edi_f, eci_f;
    logic emo_edge, edi_edge, eci_edge;

    ein_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_emo_filter (
        .clk       (clk),
        .resetn    (resetn),
        .din       (EMO_PAD),
        .dout      (emo_f),
        .dout_edge (emo_edge)
    );

    ein_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_edi_filter (
        .clk       (clk),
        .resetn    (resetn),
        .din       (EDI_PAD),
        .dout      (edi_f),
        .dout_edge (edi_edge)
    );

    ein_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_eci_filter (
        .clk       (clk),
        .resetn    (resetn),
        .din       (ECI_PAD),
        .dout      (eci_f),
        .dout_edge (eci_edge)
    );

    logic emo_rise, emo_fall, any_edge;
    assign emo_rise = emo_edge & emo_f;
    assign emo_fall = emo_edge & ~emo_f;
    assign any_edge = emo_edge | edi_edge | eci_edge;

    ein_state_e           state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [7:0]           data_q, data_d;
    logic                 latch_q, latch_d;
    logic                 partial_q, partial_d;
    logic                 timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        latch_d   = 1'b0;
        partial_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (emo_rise) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    tmo_d     = TIMEOUT_W'(TIMEOUT_CYCLES);
                    state_d   = RECV;
                end
            end
            RECV: begin
                // End of frame wins over a coincident ECI edge.
                if (emo_fall) begin
                    partial_d = (bit_cnt_q != 3'd0);
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    if (eci_edge) begin
                        shift_d   = {shift_q[6:0], edi_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(EIN_BITS_PER_CHAR - 1)) begin
                            data_d  = {shift_q[6:0], edi_f};
                            latch_d = 1'b1;
                        end
                    end
                    if (any_edge) begin
                        tmo_d = TIMEOUT_W'(TIMEOUT_CYCLES);
                    end else if (tmo_q == '0) begin
                        timeout_d = 1'b1;
                        state_d   = DRAIN;
                    end else begin
                        tmo_d = tmo_q - TIMEOUT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!emo_f) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            latch_q   <= 1'b0;
            partial_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            latch_q   <= latch_d;
            partial_q <= partial_d;
            timeout_q <= timeout_d;
        end
    end

    assign out_frame_data       = data_q;
    assign out_frame_data_latch = latch_q;
    assign out_frame_valid      = (state_q == RECV);
    assign err_partial          = partial_q;
    assign err_timeout          = timeout_q;

endmodule

// File: tb/tb_ein_rx.sv
// Randomized self-checking bench for ein_rx against a message-level model:
// bits sent per frame become expected bytes, latch cycles and error pulses.
module tb_ein_rx;

    localparam int unsigned F    = 4;
    localparam int unsigned TMO  = 200;
    localparam int unsigned STEP = 50;
    localparam int unsigned LAT  = F + 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       emo = 1'b0, edi = 1'b0, eci = 1'b0;
    logic [7:0] data;
    logic       latch, valid, partial, timeout;

    ein_rx #(
        .FILTER_CYCLES  (F),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_W      (16)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .EMO_PAD              (emo),
        .EDI_PAD              (edi),
        .ECI_PAD              (eci),
        .out_frame_data       (data),
        .out_frame_data_latch (latch),
        .out_frame_valid      (valid),
        .err_partial          (partial),
        .err_timeout          (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observations.
    logic [7:0] obs_bytes[$];
    int         obs_cyc[$];
    int         n_partial = 0, n_timeout = 0;
    int         partial_cyc = -1, timeout_cyc = -1, rise_cyc = -1, fall_cyc = -1;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (latch) begin
            obs_bytes.push_back(data);
            obs_cyc.push_back(cyc);
            check("latch_in_frame", valid, 1'b1);
        end
        if (partial) begin
            n_partial++;
            partial_cyc = cyc;
            check("partial_on_fall", {prev_valid, valid}, 2'b10);
        end
        if (timeout) begin
            n_timeout++;
            timeout_cyc = cyc;
            check("timeout_on_fall", {prev_valid, valid}, 2'b10);
        end
        if (valid && !prev_valid) rise_cyc = cyc;
        if (!valid && prev_valid) fall_cyc = cyc;
        prev_valid = valid;
    end

    // Model state.
    logic [7:0] exp_bytes[$];
    int         exp_cyc[$];
    logic [7:0] acc = '0;
    int         nbits = 0;
    bit         aborted = 1'b0;
    bit         part_this = 1'b0;
    int         exp_partial = 0, exp_timeout = 0;
    int         exp_partial_cyc = 0, exp_rise = 0, exp_fall = 0;
    int         last_toggle = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic record(input logic b);
        last_toggle = cyc;
        if (!aborted) begin
            acc = {acc[6:0], b};
            nbits++;
            if (nbits % 8 == 0) begin
                exp_bytes.push_back(acc);
                exp_cyc.push_back(cyc + LAT);
            end
        end
    endtask

    task automatic send_bit(input logic b, input bit same);
        if (same) begin
            edi = b;
            eci = ~eci;
            record(b);
            step(STEP);
        end else begin
            edi = b;
            step(STEP / 2);
            eci = ~eci;
            record(b);
            step(STEP / 2);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit same);
        for (int i = 7; i >= 0; i--) send_bit(v[i], same);
    endtask

    task automatic emo_hi();
        emo = 1'b1;
        nbits = 0;
        aborted = 1'b0;
        part_this = 1'b0;
        exp_rise = cyc + LAT;
        step(STEP);
    endtask

    task automatic emo_lo();
        emo = 1'b0;
        part_this = 1'b0;
        if (!aborted && (nbits % 8 != 0)) begin
            part_this = 1'b1;
            exp_partial++;
            exp_partial_cyc = cyc + LAT;
        end
        exp_fall = cyc + LAT;
        step(STEP);
    endtask

    task automatic end_msg(input string tag, input bit chk_frame);
        int n;
        emo_lo();
        check({tag, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
        n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_byte"}, obs_bytes[i], exp_bytes[i]);
            check({tag, "_latch_cyc"}, obs_cyc[i], exp_cyc[i]);
        end
        check({tag, "_partial_cnt"}, n_partial, exp_partial);
        if (part_this) check({tag, "_partial_cyc"}, partial_cyc, exp_partial_cyc);
        check({tag, "_timeout_cnt"}, n_timeout, exp_timeout);
        if (chk_frame) begin
            check({tag, "_valid_rise"}, rise_cyc, exp_rise);
            check({tag, "_valid_fall"}, fall_cyc, exp_fall);
        end
        obs_bytes.delete();
        obs_cyc.delete();
        exp_bytes.delete();
        exp_cyc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, data, 8'h00);
        check({tag, "_latch"}, latch, 1'b0);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_partial"}, partial, 1'b0);
        check({tag, "_timeout"}, timeout, 1'b0);
    endtask

    initial begin
        int          nb, stray;
        logic [7:0]  rb;
        logic [7:0]  g;

        step(3);
        check_all_zero("reset");
        resetn = 1'b1;
        step(5);

        // Two-byte message.
        emo_hi();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        end_msg("a5_3c", 1'b1);

        // 11 toggles: one byte plus 3 stray bits.
        emo_hi();
        send_byte(8'h6D, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        end_msg("stray", 1'b1);

        // Abort by timeout, ECI ignored while draining, then a fresh message.
        emo_hi();
        for (int i = 0; i < 3; i++) send_bit(i[0], 1'b0);
        step(250);
        aborted = 1'b1;
        exp_timeout++;
        check("timeout_cnt", n_timeout, exp_timeout);
        check("valid_after_timeout", valid, 1'b0);
        check("timeout_window",
              (timeout_cyc >= last_toggle + int'(LAT + TMO) - 5) &&
              (timeout_cyc <= last_toggle + int'(LAT + TMO) + 10), 1'b1);
        send_byte(8'h42, 1'b0);
        check("drain_no_latch", obs_bytes.size(), 0);
        emo_lo();
        emo_hi();
        send_byte(8'hFF, 1'b0);
        end_msg("after_timeout", 1'b1);

        // Short glitches on ECI and EDI between real bit transitions.
        emo_hi();
        g = 8'h81;
        for (int i = 7; i >= 0; i--) begin
            edi = g[i];
            step(10);
            eci = ~eci;
            step(2);
            eci = ~eci;
            step(5);
            edi = ~edi;
            step(2);
            edi = ~edi;
            step(8);
            eci = ~eci;
            record(g[i]);
            step(23);
        end
        end_msg("glitch", 1'b1);

        // Reset in the middle of 8'h55, then a clean 8'h55.
        emo_hi();
        g = 8'h55;
        for (int i = 7; i >= 4; i--) send_bit(g[i], 1'b0);
        step(10);
        resetn = 1'b0;
        step(1);
        check_all_zero("mid_reset");
        resetn = 1'b1;
        emo = 1'b0;
        acc = '0;
        nbits = 0;
        obs_bytes.delete();
        obs_cyc.delete();
        step(STEP);
        emo_hi();
        send_byte(8'h55, 1'b0);
        end_msg("post_reset", 1'b1);

        // EDI and ECI changing in the same cycle.
        emo_hi();
        send_byte(8'h96, 1'b1);
        end_msg("same_cycle", 1'b1);

        // Randomized messages.
        for (int k = 0; k < 6; k++) begin
            nb = $urandom_range(1, 2);
            stray = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
            emo_hi();
            for (int j = 0; j < nb; j++) begin
                rb = 8'($urandom);
                send_byte(rb, bit'($urandom_range(0, 1)));
            end
            for (int s = 0; s < stray; s++) send_bit(1'($urandom_range(0, 1)), 1'b0);
            end_msg("random", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
